// File: rtl/key_debounce_pkg.sv
// Shared constants for the key/switch debouncer: default timing and the idle
// (released / off) level of each channel kind.
package key_debounce_pkg;

    // 1 ms sample tick at 50 MHz
    localparam int   DEB_TICK_DIV_DEFAULT     = 50000;
    // 10 consecutive differing ticks (10 ms) before a new level is accepted
    localparam int   DEB_STABLE_TICKS_DEFAULT = 10;
    // Push-buttons are active-low, so idle is high
    localparam logic DEB_KEY_IDLE             = 1'b1;
    // Slide switches idle low
    localparam logic DEB_SW_IDLE              = 1'b0;

endpackage

// File: rtl/key_debounce_deb_chan.sv
// One debounce channel: 2-FF synchroniser, stability counter and output flop.
// The counter only advances on sample ticks; any tick where the synchronised
// input matches the output restarts the count, so short bounces are dropped.
// toggle is a registered one-cycle pulse aligned with the output change.
module deb_chan #(
    parameter logic IDLE         = 1'b0,
    parameter int   STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic out,
    output logic toggle
);

    localparam int            CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_out;
    logic          r_toggle;
    logic [CW-1:0] r_cnt;

    // Synchronise the raw pin and accept a new level after STABLE_TICKS differing ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= IDLE;
            r_sync2  <= IDLE;
            r_out    <= IDLE;
            r_toggle <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= raw;
            r_sync2  <= r_sync1;
            r_toggle <= 1'b0;
            if (tick) begin
                if (r_sync2 == r_out) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_out    <= r_sync2;
                    r_cnt    <= '0;
                    r_toggle <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign out    = r_out;
    assign toggle = r_toggle;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the board push-buttons (active-low) and slide switches.
// Holds the shared sample-tick prescaler, one deb_chan per channel and the
// OR of all channel toggles into the single-cycle changed pulse.
// Build option DEBOUNCE_SW_EN: when defined, switches are debounced like keys
// and contribute to changed; otherwise switches are only 2-FF synchronised.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NKEYS        = 4,
    parameter int NSW          = 8,
    parameter int TICK_DIV     = DEB_TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys_n_in,
    input  logic [NSW-1:0]   sw_in,
    output logic [NKEYS-1:0] keys_n_out,
    output logic [NSW-1:0]   sw_out,
    output logic             changed
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [NKEYS-1:0] w_key_toggle;
    logic             w_sw_any;

    assign w_tick = (r_presc == PRESC_LAST);

    // Free-running prescaler, wraps at TICK_DIV-1; first tick TICK_DIV cycles after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            deb_chan #(
                .IDLE         (DEB_KEY_IDLE),
                .STABLE_TICKS (STABLE_TICKS)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (w_tick),
                .raw    (keys_n_in[gi]),
                .out    (keys_n_out[gi]),
                .toggle (w_key_toggle[gi])
            );
        end
    endgenerate

`ifdef DEBOUNCE_SW_EN
    logic [NSW-1:0] w_sw_toggle;

    generate
        for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
            deb_chan #(
                .IDLE         (DEB_SW_IDLE),
                .STABLE_TICKS (STABLE_TICKS)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (w_tick),
                .raw    (sw_in[gi]),
                .out    (sw_out[gi]),
                .toggle (w_sw_toggle[gi])
            );
        end
    endgenerate

    assign w_sw_any = |w_sw_toggle;
`else
    logic [NSW-1:0] r_sw_sync1;
    logic [NSW-1:0] r_sw_sync2;

    // Switches only need metastability protection: plain 2-FF synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_sync1 <= {NSW{DEB_SW_IDLE}};
            r_sw_sync2 <= {NSW{DEB_SW_IDLE}};
        end else begin
            r_sw_sync1 <= sw_in;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    assign sw_out   = r_sw_sync2;
    assign w_sw_any = 1'b0;
`endif

    assign changed = (|w_key_toggle) | w_sw_any;

endmodule

// File: tb/tb_key_debounce.sv
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int NK = 4;
    localparam int NS = 8;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int NC = NK + NS;
`ifdef DEBOUNCE_SW_EN
    localparam int NDEB = NC;
`else
    localparam int NDEB = NK;
`endif
    localparam logic [NC-1:0] IDLE = {{NS{1'b0}}, {NK{1'b1}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keys_n_in = '1;
    logic [NS-1:0] sw_in = '0;
    logic [NK-1:0] keys_n_out;
    logic [NS-1:0] sw_out;
    logic          changed;

    key_debounce #(
        .NKEYS        (NK),
        .NSW          (NS),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys_n_in  (keys_n_in),
        .sw_in      (sw_in),
        .keys_n_out (keys_n_out),
        .sw_out     (sw_out),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a channel adopts the level it saw two edges ago once
    // that level has disagreed with the output on ST consecutive sample ticks.
    logic [NC-1:0] m_out = IDLE;
    logic [NC-1:0] m_h1  = IDLE;   // raw sampled one edge ago
    logic [NC-1:0] m_h2  = IDLE;   // raw sampled two edges ago
    int            m_diff_ticks[NC];
    int            m_edges = 0;
    logic          m_changed = 1'b0;
    int            pulses = 0;
    int            cyc_no = 0;

    task automatic model_edge(input logic r, input logic [NC-1:0] raw);
        logic is_tick;
        m_changed = 1'b0;
        if (r) begin
            m_out = IDLE; m_h1 = IDLE; m_h2 = IDLE; m_edges = 0;
            for (int i = 0; i < NC; i++) m_diff_ticks[i] = 0;
            return;
        end
        is_tick = ((m_edges % TD) == TD - 1);
        if (is_tick) begin
            for (int i = 0; i < NDEB; i++) begin
                if (m_h2[i] == m_out[i]) m_diff_ticks[i] = 0;
                else if (m_diff_ticks[i] + 1 >= ST) begin
                    m_out[i] = m_h2[i]; m_diff_ticks[i] = 0; m_changed = 1'b1;
                end else m_diff_ticks[i] = m_diff_ticks[i] + 1;
            end
        end
        for (int i = NDEB; i < NC; i++) m_out[i] = m_h1[i];
        m_h2 = m_h1;
        m_h1 = raw;
        m_edges++;
    endtask

    // Advance n clock cycles, checking every cycle against the model
    task automatic cyc(input int n);
        logic [NC-1:0] raw;
        logic          r;
        for (int k = 0; k < n; k++) begin
            raw = {sw_in, keys_n_in};
            r   = rst;
            @(posedge clk);
            model_edge(r, raw);
            cyc_no++;
            @(negedge clk);
            check("keys_n_out", 32'(keys_n_out), 32'(m_out[NK-1:0]));
            check("sw_out", 32'(sw_out), 32'(m_out[NC-1:NK]));
            check("changed", 32'(changed), 32'(m_changed));
            if (changed) pulses++;
        end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) m_diff_ticks[i] = 0;

        // 1. reset held 3 cycles
        rst = 1'b1;
        cyc(3);
        check("rst_keys", 32'(keys_n_out), 32'h0000_000F);
        check("rst_sw", 32'(sw_out), 32'h0);
        check("rst_changed", 32'(changed), 32'h0);
        rst = 1'b0;
        $display("txn reset released at cycle %0d", cyc_no);

        // 2. key0 pressed right after release: ticks at edges 3,7,11 -> falls after edge 12
        keys_n_in[0] = 1'b0;
        pulses = 0;
        cyc(11);
        check("key0_before_3rd_tick", 32'(keys_n_out), 32'hF);
        cyc(1);
        check("key0_fall", 32'(keys_n_out), 32'hE);
        check("key0_changed", 32'(changed), 32'h1);
        cyc(1);
        check("key0_changed_1cyc", 32'(changed), 32'h0);
        check("key0_pulses", 32'(pulses), 32'h1);
        $display("txn key0 press, keys_n_out=%b", keys_n_out);

        // 3. key1 bounce: low 2 ticks, high 1 tick, low again
        cyc($urandom_range(0, TD - 1));
        pulses = 0;
        keys_n_in[1] = 1'b0; cyc(2 * TD);
        keys_n_in[1] = 1'b1; cyc(TD);
        check("bounce_no_change", 32'(keys_n_out[1]), 32'h1);
        keys_n_in[1] = 1'b0; cyc((ST + 2) * TD);
        check("bounce_final", 32'(keys_n_out[1]), 32'h0);
        check("bounce_pulses", 32'(pulses), 32'h1);
        $display("txn key1 bounce, keys_n_out=%b pulses=%0d", keys_n_out, pulses);

        // 4. key3 and sw7 change together
        pulses = 0;
        keys_n_in[3] = 1'b0;
        sw_in[7] = 1'b1;
        cyc((ST + 2) * TD);
        check("simul_key3", 32'(keys_n_out[3]), 32'h0);
        check("simul_sw7", 32'(sw_out[7]), 32'h1);
        check("simul_pulses", 32'(pulses), 32'h1);
        $display("txn key3+sw7, keys_n_out=%b sw_out=%h pulses=%0d", keys_n_out, sw_out, pulses);

        // 5. reset while key0 has seen 2 differing ticks
        keys_n_in[0] = 1'b1;
        cyc((ST + 2) * TD);
        check("key0_release", 32'(keys_n_out[0]), 32'h1);
        keys_n_in[0] = 1'b0;
        begin
            int budget = 100;
            while (m_diff_ticks[0] != 2 && budget > 0) begin cyc(1); budget--; end
            check("cnt2_reached", 32'(budget > 0), 32'h1);
        end
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("mid_rst_key0", 32'(keys_n_out[0]), 32'h1);
        cyc(11);
        check("post_rst_no_early", 32'(keys_n_out[0]), 32'h1);
        cyc(1);
        check("post_rst_fall", 32'(keys_n_out[0]), 32'h0);
        $display("txn reset mid-count, keys_n_out=%b", keys_n_out);

        // 6. switch pattern
        keys_n_in = '1;
        cyc((ST + 2) * TD);
        pulses = 0;
        sw_in = 8'hA5;
        cyc(1);
`ifndef DEBOUNCE_SW_EN
        check("sw_not_yet", 32'(sw_out == 8'hA5), 32'h0);
`endif
        cyc(1);
`ifndef DEBOUNCE_SW_EN
        check("sw_sync_2cyc", 32'(sw_out), 32'hA5);
        check("sw_no_changed", 32'(pulses), 32'h0);
`endif
        cyc((ST + 2) * TD);
        check("sw_final", 32'(sw_out), 32'hA5);
        $display("txn sw_in=A5, sw_out=%h", sw_out);

        // Randomised segments, with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1; cyc($urandom_range(1, 2)); rst = 1'b0;
            end
            keys_n_in = NK'($urandom);
            sw_in     = NS'($urandom);
            cyc($urandom_range(1, 16));
            $display("txn rand %0d keys_n_in=%b sw_in=%h keys_n_out=%b sw_out=%h",
                     s, keys_n_in, sw_in, keys_n_out, sw_out);
        end
        keys_n_in = '1;
        sw_in = '0;
        cyc((ST + 2) * TD);
        check("final_idle_keys", 32'(keys_n_out), 32'hF);
        check("final_idle_sw", 32'(sw_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
